// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS core front end.
//   RESET_VECTOR_DEFAULT : PC loaded on reset unless a block overrides it
//   NOP_INSTR            : encoding used when a fetch is suppressed (sll $0,$0,0)
//   INSTR_WIDTH          : width of one instruction word
//   fetch_entry_t        : one fetch-queue slot {pc, instr}
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int          INSTR_WIDTH          = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock/reset signal of the fetch stage.
//   redirect_valid/redirect_target : PC change request from execute
//   rom_addr/rom_data              : combinational instruction ROM port
//   inst_valid/inst_ready          : handshake towards decode
//   inst_data/inst_pc/inst_pc_plus4: head instruction and its PCs
//   fetch_fault                    : sticky out-of-range fetch flag
// Modports:
//   master : the fetch unit itself
//   slave  : the surroundings (execute, ROM, decode)
// -----------------------------------------------------------------------------
interface fetch_unit_if;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        fetch_fault;

  modport master (
    input  redirect_valid, redirect_target, rom_data, inst_ready,
    output rom_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4, fetch_fault
  );

  modport slave (
    output redirect_valid, redirect_target, rom_data, inst_ready,
    input  rom_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4, fetch_fault
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : write pushEntry at the tail (ignored when full unless popping)
//   pop          : drop the head entry (ignored when empty)
//   flush        : discard all entries; wins over push and pop
//   pushEntry    : entry to write
//   headEntry    : oldest entry, read straight from storage
//   count        : number of valid entries
//   full, empty  : occupancy flags
// A push and a pop in the same cycle on a full queue both take effect, so the
// queue sustains one entry per cycle.
// -----------------------------------------------------------------------------
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 pushEntry,
  output fetch_entry_t                 headEntry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush;
  logic          doPop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign headEntry = mem_q[rdPtr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPop) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      if (doPush) begin
        wrPtr_d = nextPtr(wrPtr_q);
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clock) begin
    if (!reset && !flush && doPush) begin
      mem_q[wrPtr_q] <= pushEntry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, reads the combinational ROM, buffers
// fetched words in fetch_queue and hands them to decode with valid/ready.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fetch_unit_if.master (redirect, ROM port, decode handshake, fault)
// Parameters:
//   RESET_VECTOR   : PC after reset
//   QUEUE_DEPTH    : fetch-queue entries, 2..8
//   ROM_ADDR_WIDTH : ROM word-index width, used by the optional range check
// Build option:
//   FETCH_RANGE_CHECK_EN : when defined, misaligned or out-of-ROM fetches set a
//   sticky fetch_fault and enqueue a NOP instead of the ROM word.
// -----------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = RESET_VECTOR_DEFAULT,
  parameter int          QUEUE_DEPTH    = 2,
  parameter int          ROM_ADDR_WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  // Elaboration-time guard on parameter ranges.
  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 8) begin : g_badQueueDepth
    $error("fetch_unit: QUEUE_DEPTH must be within 2..8");
  end
  if (ROM_ADDR_WIDTH < 1 || ROM_ADDR_WIDTH > 29) begin : g_badRomWidth
    $error("fetch_unit: ROM_ADDR_WIDTH must be within 1..29");
  end

  logic [31:0]   pc_q, pc_d;
  logic          pop;
  logic          fetchFire;
  logic [31:0]   fetchInstr;
  fetch_entry_t  pushEntry;
  fetch_entry_t  headEntry;
  logic [CW-1:0] qCount;
  logic          qFull;
  logic          qEmpty;

  assign bus.rom_addr = pc_q;

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // fetch while decode is consuming. A redirect suppresses the fetch because
  // the current PC is on the wrong path.
  assign pop       = bus.inst_valid & bus.inst_ready;
  assign fetchFire = ~reset & ~bus.redirect_valid & (~qFull | pop);

  // Next-PC selection: redirect beats sequential advance; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_target;
    end else if (fetchFire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_RANGE_CHECK_EN
  logic pcBad;
  logic fault_q, fault_d;

  // Anything misaligned or beyond the ROM would alias onto a real word.
  assign pcBad = (pc_q[1:0] != 2'b00) | (pc_q[31:ROM_ADDR_WIDTH+2] != '0);

  // Fault is sticky until reset; fetching carries on with NOPs.
  always_comb begin
    fault_d = fault_q;
    if (fetchFire && pcBad) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetchInstr      = pcBad ? NOP_INSTR : bus.rom_data;
  assign bus.fetch_fault = fault_q;
`else
  assign fetchInstr      = bus.rom_data;
  assign bus.fetch_fault = 1'b0;
`endif

  always_comb begin
    pushEntry       = '0;
    pushEntry.pc    = pc_q;
    pushEntry.instr = fetchInstr;
  end

  // A redirect flushes after any same-cycle pop has been handed to decode.
  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (fetchFire),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .pushEntry (pushEntry),
    .headEntry (headEntry),
    .count     (qCount),
    .full      (qFull),
    .empty     (qEmpty)
  );

  // Head fields read as zero while the queue is empty so reset and flushed
  // states present a clean bus to decode.
  assign bus.inst_valid    = (qCount != '0);
  assign bus.inst_data     = qEmpty ? '0 : headEntry.instr;
  assign bus.inst_pc       = qEmpty ? '0 : headEntry.pc;
  assign bus.inst_pc_plus4 = qEmpty ? '0 : headEntry.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a behavioural ROM whose word at index i is
// 0x11111111*(i+1), aliased on rom_addr[9:2] and driving 0 during reset.
// Honours FETCH_RANGE_CHECK_EN for the out-of-range fetch expectations.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import mips_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_VECTOR   (32'h0000_0000),
    .QUEUE_DEPTH    (2),
    .ROM_ADDR_WIDTH (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic        EXP_FAULT     = 1'b1;
  localparam logic [31:0] EXP_FAR_DATA  = 32'h0000_0000;
`else
  localparam logic        EXP_FAULT     = 1'b0;
  localparam logic [31:0] EXP_FAR_DATA  = 32'h1111_1111;
`endif

  // Behavioural ROM contents.
  function automatic logic [31:0] romWord(input logic [7:0] idx);
    logic [31:0] w;
    w = 32'h1111_1111 * ({24'b0, idx} + 32'd1);
    return w;
  endfunction

  assign bus.rom_data = reset ? 32'h0 : romWord(bus.rom_addr[9:2]);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed no end of sequence, expected finish before 50000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst, input logic redir,
                               input logic [31:0] target, input logic ready);
    reset               = rst;
    bus.redirect_valid  = redir;
    bus.redirect_target = target;
    bus.inst_ready      = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("rst_data", bus.inst_data, 32'h0);
    checkOutput("rst_pc", bus.inst_pc, 32'h0);
    checkOutput("rst_pc4", bus.inst_pc_plus4, 32'h0);
    checkOutput("rst_fault", {31'b0, bus.fetch_fault}, 32'h0);
    checkOutput("rst_romaddr", bus.rom_addr, 32'h0);

    // Streaming with decode always ready
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("s1_valid0", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s1_pc0", bus.inst_pc, 32'h0);
    checkOutput("s1_data0", bus.inst_data, 32'h1111_1111);
    checkOutput("s1_pc4_0", bus.inst_pc_plus4, 32'h4);
    checkOutput("s1_romaddr0", bus.rom_addr, 32'h4);
    @(negedge clock);
    checkOutput("s1_pc1", bus.inst_pc, 32'h4);
    checkOutput("s1_data1", bus.inst_data, 32'h2222_2222);
    @(negedge clock);
    checkOutput("s1_pc2", bus.inst_pc, 32'h8);
    checkOutput("s1_data2", bus.inst_data, 32'h3333_3333);
    checkOutput("s1_romaddr2", bus.rom_addr, 32'hC);

    // Backpressure: queue fills to 2 and the PC freezes
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("s2_rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("s2_hold_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s2_hold_pc", bus.inst_pc, 32'h0);
    checkOutput("s2_hold_data", bus.inst_data, 32'h1111_1111);
    checkOutput("s2_freeze_romaddr", bus.rom_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("s2_rel_valid1", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s2_rel_pc1", bus.inst_pc, 32'h4);
    @(negedge clock);
    checkOutput("s2_rel_valid2", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s2_rel_pc2", bus.inst_pc, 32'h8);
    checkOutput("s2_rel_data2", bus.inst_data, 32'h3333_3333);
    @(negedge clock);
    checkOutput("s2_rel_pc3", bus.inst_pc, 32'hC);

    // Redirect to 0x40 while full, with a same-cycle pop of 0x0
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("s3_full_romaddr", bus.rom_addr, 32'h8);
    checkOutput("s3_head_pc", bus.inst_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s3_flush_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("s3_romaddr", bus.rom_addr, 32'h40);
    @(negedge clock);
    checkOutput("s3_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s3_pc", bus.inst_pc, 32'h40);
    checkOutput("s3_data", bus.inst_data, 32'h2222_2221);
    checkOutput("s3_pc4", bus.inst_pc_plus4, 32'h44);

    // Back-to-back redirects: 0x20 overridden by 0x80
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
    @(negedge clock);
    checkOutput("s4_valid_a", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("s4_romaddr_a", bus.rom_addr, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    @(negedge clock);
    checkOutput("s4_valid_b", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("s4_romaddr_b", bus.rom_addr, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("s4_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s4_pc", bus.inst_pc, 32'h80);
    checkOutput("s4_data", bus.inst_data, 32'h3333_3331);
    @(negedge clock);
    checkOutput("s4_pc_next", bus.inst_pc, 32'h84);

    // Redirect to an out-of-range, misaligned PC
    applyStimulus(1'b0, 1'b1, 32'h402, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s5_flush_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("s5_romaddr", bus.rom_addr, 32'h402);
    @(negedge clock);
    checkOutput("s5_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s5_pc", bus.inst_pc, 32'h402);
    checkOutput("s5_pc4", bus.inst_pc_plus4, 32'h406);
    checkOutput("s5_data", bus.inst_data, EXP_FAR_DATA);
    checkOutput("s5_fault", {31'b0, bus.fetch_fault}, {31'b0, EXP_FAULT});
    @(negedge clock);
    checkOutput("s5_pc_next", bus.inst_pc, 32'h406);
    checkOutput("s5_fault_sticky", {31'b0, bus.fetch_fault}, {31'b0, EXP_FAULT});

    // Reset mid-stream with two entries queued
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("s6_held_pc", bus.inst_pc, 32'h406);
    checkOutput("s6_freeze_romaddr", bus.rom_addr, 32'h40E);
    checkOutput("s6_fault_held", {31'b0, bus.fetch_fault}, {31'b0, EXP_FAULT});
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
    @(negedge clock);
    checkOutput("s6_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("s6_romaddr", bus.rom_addr, 32'h0);
    checkOutput("s6_pc", bus.inst_pc, 32'h0);
    checkOutput("s6_data", bus.inst_data, 32'h0);
    checkOutput("s6_pc4", bus.inst_pc_plus4, 32'h0);
    checkOutput("s6_fault", {31'b0, bus.fetch_fault}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("s6_restart_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("s6_restart_pc", bus.inst_pc, 32'h0);
    checkOutput("s6_restart_data", bus.inst_data, 32'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle/pipelined MIPS core.
- Owns the PC and drives the address of the combinational-read instruction ROM. Captures the returned, already byte-swapped word.
- Buffers fetched words in a small queue and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush any pending fetched words.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, entries in the fetch queue; legal values 2..8.
- ROM_ADDR_WIDTH, 8, word-index width of the attached ROM; used only by the optional range check.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_target  in  32  new PC when redirect_valid=1
- rom_addr  out  32  byte address to the ROM; equals current PC (combinational)
- rom_data  in  32  instruction word for rom_addr, valid in the same cycle
- inst_valid  out  1  queue head holds a valid instruction
- inst_ready  in  1  decode accepts the head this cycle
- inst_data  out  32  head instruction word
- inst_pc  out  32  PC of the head instruction
- inst_pc_plus4  out  32  inst_pc+4, modulo 2^32
- fetch_fault  out  1  sticky fault flag; constant 0 unless FETCH_RANGE_CHECK_EN

Behaviour:
- Reset values, synchronous, highest priority:
  - pc=RESET_VECTOR, queue count=0, read/write pointers=0.
  - inst_valid=0; inst_data, inst_pc and inst_pc_plus4=0; fetch_fault=0.
- Definitions:
  - pop = inst_valid & inst_ready.
  - fetch_fire = !reset & !redirect_valid & (count<QUEUE_DEPTH | pop).
- On fetch_fire:
  - Queue entry {pc, rom_data} is written at the tail.
  - pc <= pc+4, wrapping modulo 2^32.
- Queue outputs:
  - Outputs are driven from the head entry and registered.
  - inst_valid = (count != 0).
- Simultaneous pop and fetch when full: both happen and count is unchanged. No stall bubble when decode is always ready, so throughput is 1 instr/cycle.
- inst_ready=0: the head holds stable. Fetch continues until count=QUEUE_DEPTH, then pc freezes.
- Redirect (cycle N):
  - pc <= redirect_target; queue flushed (count=0); no fetch in cycle N.
  - A pop in cycle N is still a completed transfer for decode, then the queue is flushed.
  - Cycle N+1: fetch at target. Cycle N+2: inst_valid=1 with inst_pc=target.
  - Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- Out-of-range PCs:
  - The ROM aliases addresses outside its range (it uses addr[ROM_ADDR_WIDTH+1:2]).
  - Without the macro, fetch performs no range or alignment check.
- Reset asserted mid-operation: the queue is discarded and pc=RESET_VECTOR in the next cycle, regardless of inst_ready or redirect_valid.
- rom_data sampled while reset=1 is ignored; the ROM drives 0 during reset.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN.
- With the macro defined:
  - On fetch_fire, if pc[1:0]!=0 or pc[31:ROM_ADDR_WIDTH+2]!=0, fetch_fault is set (sticky until reset).
  - The entry is enqueued with inst_data=32'h0000_0000 (a NOP) instead of rom_data.
  - Fetching continues.
- Without the macro: fetch_fault is tied 0, no comparison logic is generated, and rom_data is always enqueued.

Decomposition:
- Shared package (mips_pkg):
  - RESET_VECTOR default and the NOP encoding 32'h0.
  - Instruction width constant (32).
  - Typedef for a fetch-queue entry {pc[31:0], instr[31:0]}.
- One sub-module: fetch_queue, a parameterised synchronous FIFO with push, pop, flush, count, full and empty, plus same-cycle push-and-pop when full.
- The PC register, next-PC mux and optional range check stay in fetch_unit.

Test Plan:
- Reset, then inst_ready=1 steady, ROM preloaded with 0x11111111, 0x22222222, … → inst_valid rises on cycle 2 after reset release; inst_pc sequence 0x0, 0x4, 0x8 on consecutive cycles; inst_data matches.
- inst_ready=0 for 5 cycles after the first valid → inst_pc held at 0x0; rom_addr freezes at 0x8 (queue full at 2). On release, 0x0, 0x4, 0x8 are delivered back-to-back with no gap.
- Redirect to 0x40 while the queue is full and pop=1 → head 0x0 consumed, 0x4 discarded; next valid instruction has inst_pc=0x40 exactly two cycles after redirect.
- Redirects to 0x20 and 0x80 in consecutive cycles → no instruction from 0x20 is ever delivered; first valid inst_pc=0x80.
- With FETCH_RANGE_CHECK_EN, redirect to 0x402 → fetch_fault=1 one cycle after the fetch; the delivered inst_data is 0x00000000; fetch_fault stays 1 until reset.
- Reset asserted mid-stream with 2 entries queued → next cycle inst_valid=0 and rom_addr=RESET_VECTOR.
